div_unit: RTL

//   Multi-cycle radix-2 restoring divider for EX-stage DIV/DIVU. EX drives operands taken

---
 rtl/div_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX-stage DIV/DIVU instructions.
// Produces {remainder, quotient} after WIDTH+1 edges. A divide by zero skips the
// iteration loop and returns zero one edge after acceptance.
//
// Handshake: start_i is a level request that the requester holds until it has
// consumed the result. A request is accepted only from IDLE when annul_i is low.
// Operands are sampled at that edge only. busy_o is high while the unit is
// working, and the requester stalls on it. ready_o qualifies result_o. Both stay
// stable in DONE while start_i stays high. Dropping start_i, or raising annul_i,
// releases the unit back to IDLE on the next edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;      // dividend bits still to be consumed; quotient bits fill in from the bottom
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder
    logic             neg_quo;  // operand signs differed on a signed divide
    logic             neg_rem;  // dividend was negative on a signed divide

    logic             accept;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept  = start_i && !annul_i;
    // Shift the next dividend bit into the partial remainder and try to subtract the divisor.
    assign trial   = {rem, dvd[WIDTH-1]};
    assign diff    = trial - {1'b0, dvs};
    assign fits    = (trial >= {1'b0, dvs});
    assign quo_fix = neg_quo ? (~dvd + 1'b1) : dvd;
    assign rem_fix = neg_rem ? (~rem + 1'b1) : rem;
    assign busy_o  = (state == BYZERO) || (state == RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = (opdata2_i == '0) ? BYZERO : RUN;
            end
            BYZERO: begin
                next_state = annul_i ? IDLE : DONE;
            end
            RUN: begin
                if (annul_i)                   next_state = IDLE;
                else if (cnt == CW'(WIDTH))    next_state = DONE;
            end
            DONE: begin
                if (annul_i || !start_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, one quotient bit per RUN edge, and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (accept && (opdata2_i != '0)) begin
                        cnt     <= '0;
                        rem     <= '0;
                        dvd     <= (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
                        dvs     <= (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
                        neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
                BYZERO: begin
                    result_o <= '0;
                    ready_o  <= !annul_i;
                end
                RUN: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt == CW'(WIDTH)) begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        rem <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], fits};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (annul_i || !start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule
